lod_pipe: RTL

Parametrised, pipelined first-one detector with a valid/ready handshake. It returns the 1-based position of the most-significant set bit (leading mode) or least-significant set bit (trailing mode) of a WIDTH-bit word, with 0 meaning no bit is set. It is the next-generation normaliser front end for the fraction PEs and replaces the fixed 16-bit combinational encoder. It fixes that encoder's output-width overflow at position WIDTH, adds per-word mode selection and backpressure, and carries a sideband tag.

---
 rtl/lod_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lod_pipe.sv
// Two-stage pipelined first-one detector (leading or trailing per word) with
// valid/ready flow control and a sideband tag carried alongside each result.

module lod_pipe_grp #(
   parameter  int GROUP = 4,
   localparam int LW    = $clog2(GROUP)
) (
   input  logic [GROUP-1:0] grp_i,
   input  logic             mode_i,
   output logic             nz_o,
   output logic [LW-1:0]    loc_o
);

   // Later hits overwrite earlier ones: ascending scan keeps the highest bit,
   // descending scan keeps the lowest.
   always_comb begin
      loc_o = '0;
      for (int j = 0; j < GROUP; j++) begin
         if (!mode_i && grp_i[j])           loc_o = LW'(j);
         if (mode_i && grp_i[GROUP-1-j])    loc_o = LW'(GROUP-1-j);
      end
   end

   assign nz_o = |grp_i;

endmodule

module lod_pipe #(
   parameter  int WIDTH = 16,
   parameter  int GROUP = 4,
   parameter  int TAG_W = 1,
   localparam int OW    = $clog2(WIDTH+1),
   localparam int NG    = WIDTH/GROUP,
   localparam int LW    = $clog2(GROUP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_pos,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   logic                   s1_valid_q, s2_valid_q;
   logic                   s1_mode_q;
   logic [TAG_W-1:0]       s1_tag_q, s2_tag_q;
   logic [NG-1:0]          nz_d, nz_q;
   logic [NG-1:0][LW-1:0]  loc_d, loc_q;
   logic [OW-1:0]          pos_d, pos_q;
   logic                   zero_d, zero_q;
   logic                   s1_adv, s2_adv;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   for (genvar g = 0; g < NG; g++) begin : g_grp
      lod_pipe_grp #(.GROUP(GROUP)) u_grp (
         .grp_i  (in_data[g*GROUP +: GROUP]),
         .mode_i (in_mode),
         .nz_o   (nz_d[g]),
         .loc_o  (loc_d[g])
      );
   end

   // Mode 0 lets every later group overwrite (highest wins); mode 1 keeps
   // only the first non-empty group. Sum is formed at OW bits so WIDTH fits.
   always_comb begin
      pos_d  = '0;
      zero_d = 1'b1;
      for (int g = 0; g < NG; g++) begin
         if (nz_q[g] && (!s1_mode_q || zero_d)) begin
            pos_d  = OW'(g*GROUP) + OW'(loc_q[g]) + OW'(1);
            zero_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_tag_q   <= '0;
         nz_q       <= '0;
         loc_q      <= '0;
         s2_valid_q <= 1'b0;
         pos_q      <= '0;
         zero_q     <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_mode_q <= in_mode;
               s1_tag_q  <= in_tag;
               nz_q      <= nz_d;
               loc_q     <= loc_d;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               pos_q    <= pos_d;
               zero_q   <= zero_d;
               s2_tag_q <= s1_tag_q;
            end
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_pos   = pos_q;
   assign out_zero  = zero_q;
   assign out_tag   = s2_tag_q;

endmodule
